// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction-memory loader
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
    localparam int HDR_BYTES      = 4;
    localparam int LANE_W         = $clog2(HDR_BYTES);
    localparam int DEFAULT_ADDR_W = 8;
endpackage

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: gathers four stream bytes little-endian into a 32-bit word
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        fire,
    input  logic [7:0]  data,
    output logic        word_complete,
    output logic [31:0] word
);
    logic [LANE_W-1:0] lane;
    logic [23:0]       shreg;
    // Earlier bytes shift down so byte k of a group ends up at bits [8k+7:8k]
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lane  <= '0;
            shreg <= '0;
        end else if (clr) begin
            lane  <= '0;
            shreg <= '0;
        end else if (fire) begin
            lane  <= lane + 1'b1;
            shreg <= {data, shreg[23:8]};
        end
    assign word_complete = fire && (lane == LANE_W'(HDR_BYTES - 1));
    assign word          = {data, shreg};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed image into instruction memory while holding the core in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    state_t          state, state_nx;
    logic [ADDR_W:0] n_words;
    logic            fire, clr, word_complete, wr, last_word;
    logic [31:0]     word;

    assign busy      = (state == HDR) || (state == DATA);
    assign done      = state == DONE;
    assign error     = state == ERR;
    assign in_ready  = busy;
    assign fire      = in_valid && in_ready;
    assign clr       = start && !busy;
    assign wr        = (state == DATA) && word_complete;
    assign last_word = (words_loaded + 1'b1) == n_words;

    imem_byte_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .fire          (fire),
        .data          (in_data),
        .word_complete (word_complete),
        .word          (word)
    );

    // Session sequencing: header decides DONE/ERR/DATA, the final data word ends the session
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = HDR;
            HDR:  if (word_complete) state_nx = (word == 32'd0) ? DONE : (word > DEPTH) ? ERR : DATA;
            DATA: if (word_complete && last_word) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // Write port, word counter and core reset; the core is released only after a full cycle in DONE
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            n_words      <= '0;
            cpu_reset    <= 1'b1;
        end else begin
            imem_we   <= wr;
            cpu_reset <= !(done && !start);
            if (state == HDR && word_complete) n_words <= word[ADDR_W:0];
            if (clr) begin
                words_loaded <= '0;
            end else if (wr) begin
                words_loaded <= words_loaded + 1'b1;
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= word;
            end
        end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the imem word-address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte-stream ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  word written.
REQ-011 cpu_reset  output  1  active-high reset held on the RISCV core until the image is loaded.
REQ-012 busy / done / error  output  1 each  session status flags.
REQ-013 words_loaded  output  ADDR_W+1  count of words written this session.

Function
REQ-014 States SHALL be IDLE, HDR, DATA, DONE and ERR.
REQ-015 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 only in HDR and DATA, combinationally from state.
REQ-017 Bytes SHALL be assembled little-endian: byte k of a group goes to bits [8k+7:8k]; a 2-bit lane counter wraps 3->0.
REQ-018 IDLE -> HDR on start, clearing the lane counter and words_loaded.
REQ-019 In HDR, four bytes SHALL form the word count N (32-bit).
REQ-020 On the 4th header byte: N=0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA with the write address set to 0.
REQ-021 In DATA, imem_we SHALL be 1 for exactly the cycle after the 4th byte of a word is accepted, with imem_addr = word index and imem_wdata = assembled word.
REQ-022 words_loaded SHALL increment on the same edge that asserts imem_we.
REQ-023 The edge that registers the Nth write SHALL move the FSM to DONE; no further bytes are accepted.
REQ-024 cpu_reset SHALL be registered, =1 in every state except DONE, deasserting one cycle after DONE is entered, i.e. after the last imem_we cycle.
REQ-025 busy SHALL be 1 in HDR/DATA; done SHALL be 1 in DONE; error SHALL be 1 in ERR.
REQ-026 start in HDR or DATA SHALL be ignored.
REQ-027 start in DONE or ERR SHALL go to HDR, clear counters and flags, and reassert cpu_reset on that edge.
REQ-028 in_valid=0 mid-word SHALL stall with the lane counter and partial word held indefinitely; there is no timeout.
REQ-029 N=DEPTH SHALL be legal, with the last write at address DEPTH-1 and words_loaded=DEPTH with no overflow.

Reset
REQ-030 On reset low, the block SHALL asynchronously enter IDLE with imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, busy=done=error=0, in_ready=0 and cpu_reset=1.
REQ-031 Reset asserted mid-session SHALL discard the partial word; no imem_we SHALL be issued after reset rises until a new start.

Structure
REQ-032 Package imem_loader_pkg SHALL hold the state enum, HDR_BYTES=4 and the default ADDR_W.
REQ-033 Sub-module imem_byte_assembler SHALL hold the lane counter and 32-bit shift register, flagging word_complete.
REQ-034 The FSM, address counter and cpu_reset register SHALL live in imem_loader.

Verification
REQ-035 Header N=2, bytes 13 00 00 00 93 00 50 00 -> writes addr0=0x00000013 and addr1=0x00500093; done=1; cpu_reset falls one cycle after the second imem_we.
REQ-036 Header N=0 -> DONE with no imem_we; words_loaded=0.
REQ-037 Header N=257 with ADDR_W=8 -> ERR; error=1; in_ready=0; cpu_reset stays 1.
REQ-038 in_valid toggled 1-0-1 every cycle during a word -> same wdata as the back-to-back case; imem_we still one cycle wide.
REQ-039 Reset low after 2 data bytes, then start and load N=1 of 0xDEADBEEF -> a single write of 0xDEADBEEF at addr 0.
REQ-040 start during DATA -> ignored; start in DONE -> cpu_reset=1 the next cycle and a reload succeeds.
